// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory feeder.
package imem_pkg;

   localparam int IMEM_ADDR_W = 8;
   localparam int IMEM_DATA_W = 32;

   localparam logic [IMEM_DATA_W-1:0] NOP_WORD = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: synchronous write, asynchronous read, contents never reset.
module imem_ram
   import imem_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DATA_W = IMEM_DATA_W
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_feeder.sv
// Loads a program from a host stream into imem_ram, then runs the CPU over it
// until the program counter leaves the loaded range.
module imem_feeder
   import imem_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DATA_W = IMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ins,
   output logic              cpu_set,
   output logic              done
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] r_end_addr;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_rdata;
   logic              w_xfer;
   logic              w_final;

   assign load_ready = (r_state != RUN);
   assign cpu_set    = (r_state == RUN);
   assign done       = (r_state == DONE);
   assign w_xfer     = load_valid && load_ready;

   // A transfer outside LOAD starts a fresh program at address 0.
   assign w_waddr = (r_state == LOAD) ? r_wr_addr : '0;
   assign w_final = load_last || (w_waddr == '1);

   // Words above end_addr may be stale from an earlier, longer program.
   assign ins = ((r_state == RUN) && (pc <= r_end_addr)) ? w_rdata : DATA_W'(NOP_WORD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_wr_addr  <= '0;
         r_end_addr <= '0;
      end else begin
         unique case (r_state)
            IDLE, LOAD, DONE: begin
               if (w_xfer) begin
                  r_wr_addr <= w_waddr + ADDR_W'(1);
                  if (w_final) begin
                     r_end_addr <= w_waddr;
                     r_state    <= RUN;
                  end else begin
                     r_state    <= LOAD;
                  end
               end
            end
            RUN: begin
               if (pc > r_end_addr) begin
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   imem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_xfer),
      .i_waddr (w_waddr),
      .i_wdata (load_data),
      .i_raddr (pc),
      .o_rdata (w_rdata)
   );

endmodule

// File: doc/imem_feeder.md
IMEM_FEEDER -- requirements
Module: imem_feeder

Interface
REQ-001 Parameter ADDR_W, default 8, program-counter and memory address width.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load_valid  input  1  host offers an instruction word.
REQ-006 load_data  input  DATA_W  instruction word to store.
REQ-007 load_last  input  1  marks the offered word as final word of the program.
REQ-008 load_ready  output  1  feeder can accept a word this cycle.
REQ-009 pc  input  ADDR_W  CPU program counter (word index).
REQ-010 ins  output  DATA_W  instruction for the CPU's ins_in.
REQ-011 cpu_set  output  1  CPU run enable.
REQ-012 done  output  1  program finished; CPU has left the loaded range.

Function
REQ-013 FSM states: IDLE, LOAD, RUN, DONE.
REQ-014 A word transfers when load_valid and load_ready are both high on a rising edge.
REQ-015 load_ready SHALL be 1 in IDLE, LOAD and DONE, and 0 in RUN.
REQ-016 Write address counter wr_addr SHALL reset to 0 on each IDLE->LOAD or DONE->LOAD transition and increment by 1 per transfer.
REQ-017 First transfer in IDLE or DONE SHALL write address 0 and enter LOAD, or RUN if load_last is also high.
REQ-018 Transfer with load_last, or the transfer writing address 2^ADDR_W-1, SHALL latch end_addr = that write address and move to RUN next cycle.
REQ-019 In RUN, cpu_set SHALL be 1.
REQ-020 In all other states, cpu_set SHALL be 0.
REQ-021 ins SHALL be combinational: mem[pc] when state is RUN and pc <= end_addr, else 0 (zero latency, same cycle as pc).
REQ-022 In RUN, pc > end_addr on a rising edge SHALL move to DONE.
REQ-023 In DONE, done SHALL be 1 and ins SHALL be 0 until a new load begins.
REQ-024 When end_addr = 2^ADDR_W-1, DONE is unreachable; RUN persists until rst (pc wraps, no overflow detection).
REQ-025 Memory contents SHALL persist across RUN/DONE; a new load overwrites from address 0, and stale words above the new end_addr are never presented on ins.
REQ-026 load_valid in RUN SHALL be ignored, with no write and no state change.

Reset
REQ-027 rst high SHALL immediately force state=IDLE, wr_addr=0, end_addr=0, cpu_set=0, done=0, load_ready=1, ins=0.
REQ-028 Reset mid-LOAD or mid-RUN SHALL abandon the program; a subsequent load restarts at address 0.
REQ-029 Memory array contents are not reset.

Structure
REQ-030 Shared package imem_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and constant NOP_WORD = 0.
REQ-031 Storage SHALL be one sub-module imem_ram: 2^ADDR_W x DATA_W, synchronous write, asynchronous read.
REQ-032 FSM, counters and output muxing SHALL reside in imem_feeder.

Verification
REQ-033 Load words 0x00500093, 0x00A00113, 0x002081B3 (last on third) with pc held at 0 -> cpu_set=1 one cycle after third transfer, ins=0x00500093.
REQ-034 In RUN, step pc 0,1,2,3 -> ins 0x00500093, 0x00A00113, 0x002081B3, then 0; DONE/done=1 the cycle after pc=3 is sampled, cpu_set=0.
REQ-035 Single-word load with load_last on the first transfer -> end_addr=0, RUN next cycle; pc=1 -> DONE.
REQ-036 Stream 256 words with load_last never asserted -> RUN after word 255; pc sweep 0..255 returns each word; pc wrap to 0 does not reach DONE.
REQ-037 Pulse rst mid-RUN at pc=1 -> cpu_set=0, ins=0, IDLE immediately; reload 2 words -> pc=2 yields 0 and DONE.
REQ-038 Hold load_valid high in RUN -> load_ready=0, memory unchanged; from DONE, new 1-word load 0xDEADBEEF -> pc=0 yields 0xDEADBEEF, pc=1 yields 0.
